// File: rtl/io_port_controller.sv
// rtl/io_port_controller.sv - memory-mapped I/O port, input sampler and compare-match timer
// Optional input debounce is enabled by defining IO_DEBOUNCE_EN.
module io_port_controller #(
  parameter logic [31:0] IO_BASE         = 32'h1001_0100,
  parameter int          IN_WIDTH        = 8,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  output logic                Select,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  localparam logic [2:0] OFF_OUT  = 3'd0;
  localparam logic [2:0] OFF_IN   = 3'd1;
  localparam logic [2:0] OFF_STAT = 3'd2;
  localparam logic [2:0] OFF_CAP  = 3'd3;
  localparam logic [2:0] OFF_CTRL = 3'd4;
  localparam logic [2:0] OFF_TMR  = 3'd5;
  localparam logic [2:0] OFF_CMP  = 3'd6;

  logic [31:0]         out_q, out_d;
  logic [31:0]         timer_q, timer_d;
  logic [31:0]         cmp_q, cmp_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic                chg_q, chg_d;
  logic                tmr_q, tmr_d;
  logic [IN_WIDTH-1:0] s1_q, s2_q, prev_q, cap_q, cap_d;
  logic [IN_WIDTH-1:0] in_data;
  logic [2:0]          off;
  logic                wr, chg_set, tmr_match;

  assign Select = (Address[31:5] == IO_BASE[31:5]) && (Address[1:0] == 2'b00);
  assign off    = Address[4:2];
  assign wr     = MemWrite && Select;

`ifdef IO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [IN_WIDTH-1:0] in_q, cand_q;
  logic [CW-1:0]       cnt_q, cnt_n;

  // cnt_n is the run length of s2 including this edge; a new candidate restarts at 1.
  assign cnt_n = (cnt_q != '0 && s2_q == cand_q) ? cnt_q + CW'(1) : CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else if (s2_q == in_q) begin
      cnt_q  <= '0;
    end else if (cnt_n == CW'(DEBOUNCE_CYCLES)) begin
      in_q   <= s2_q;
      cnt_q  <= '0;
    end else begin
      cand_q <= s2_q;
      cnt_q  <= cnt_n;
    end
  end
  assign in_data = in_q;
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES == 0);
  assign in_data = s2_q;
`endif

  assign chg_set   = (in_data != prev_q);
  assign tmr_match = ctrl_q[0] && (timer_q == cmp_q);

  always_comb begin
    out_d   = out_q;
    ctrl_d  = ctrl_q;
    cmp_d   = cmp_q;
    timer_d = timer_q;
    cap_d   = chg_set ? in_data : cap_q;
    // Sets are OR-ed in after the W1C clear so a coincident event is never lost.
    chg_d   = (chg_q & ~(wr && off == OFF_STAT && WriteData[0])) | chg_set;
    tmr_d   = (tmr_q & ~(wr && off == OFF_STAT && WriteData[1])) | tmr_match;
    if (ctrl_q[0]) timer_d = tmr_match ? 32'h0 : timer_q + 32'd1;
    if (wr) begin
      case (off)
        OFF_OUT:  out_d   = WriteData;
        OFF_CTRL: ctrl_d  = WriteData[2:0];
        OFF_TMR:  timer_d = WriteData;
        OFF_CMP:  cmp_d   = WriteData;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      timer_q <= '0;
      cmp_q   <= '0;
      ctrl_q  <= '0;
      chg_q   <= 1'b0;
      tmr_q   <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      cap_q   <= '0;
    end else begin
      out_q   <= out_d;
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      ctrl_q  <= ctrl_d;
      chg_q   <= chg_d;
      tmr_q   <= tmr_d;
      s1_q    <= PortIn;
      s2_q    <= s1_q;
      prev_q  <= in_data;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    ReadData = 32'h0;
    if (MemRead && Select) begin
      case (off)
        OFF_OUT:  ReadData = out_q;
        OFF_IN:   ReadData = 32'(in_data);
        OFF_STAT: ReadData = {30'h0, tmr_q, chg_q};
        OFF_CAP:  ReadData = 32'(cap_q);
        OFF_CTRL: ReadData = {29'h0, ctrl_q};
        OFF_TMR:  ReadData = timer_q;
        OFF_CMP:  ReadData = cmp_q;
        default:  ReadData = 32'h0;
      endcase
    end
  end

  assign PortOut = out_q;
  assign Irq     = (chg_q & ctrl_q[1]) | (tmr_q & ctrl_q[2]);

endmodule

// File: tb/tb_io_port_controller.sv
// tb/tb_io_port_controller.sv - directed-vector bench for io_port_controller
`timescale 1ns/1ps
module tb_io_port_controller;
  localparam logic [31:0] B = 32'h1001_0100;
`ifdef IO_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic        MemWrite, MemRead, Select, Irq;
  logic [7:0]  PortIn;
  logic [31:0] rd_v;
  int          vectors = 0;
  int          miscompares = 0;

  always #10 clk = ~clk;

  io_port_controller dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData), .Select(Select),
    .PortIn(PortIn), .PortOut(PortOut), .Irq(Irq)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    Address = a; MemRead = 1'b1;
    #1;
    d = ReadData;
    MemRead = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    vectors++; if (PortOut !== 32'h0) begin miscompares++; $display("FAIL reset_portout got %h exp %h", PortOut, 32'h0); end
    vectors++; if (Irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b exp 0", Irq); end
    tick(4);
    rd(B + 32'h08, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL reset_status got %h exp %h", rd_v, 32'h0); end
    rd(B + 32'h14, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL reset_timer got %h exp %h", rd_v, 32'h0); end
  endtask

  task automatic test_out_port;
    wr(B, 32'hDEAD_BEEF);
    vectors++; if (PortOut !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL portout got %h exp %h", PortOut, 32'hDEAD_BEEF); end
    rd(B, rd_v);
    vectors++; if (rd_v !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL out_read got %h exp %h", rd_v, 32'hDEAD_BEEF); end
    Address = B + 32'h2;
    #1;
    vectors++; if (Select !== 1'b0) begin miscompares++; $display("FAIL unaligned_select got %b exp 0", Select); end
    wr(B + 32'h2, 32'h1234_5678);
    vectors++; if (PortOut !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL unaligned_write got %h exp %h", PortOut, 32'hDEAD_BEEF); end
    rd(B + 32'h2, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL unaligned_read got %h exp %h", rd_v, 32'h0); end
  endtask

  task automatic test_input;
    PortIn = 8'hA5;
    tick(LAT - 1);
    rd(B + 32'h04, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL in_early got %h exp %h", rd_v, 32'h0); end
    tick(1);
    rd(B + 32'h04, rd_v);
    vectors++; if (rd_v !== 32'hA5) begin miscompares++; $display("FAIL in_data got %h exp %h", rd_v, 32'hA5); end
    rd(B + 32'h08, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL chg_early got %h exp %h", rd_v, 32'h0); end
    tick(1);
    rd(B + 32'h08, rd_v);
    vectors++; if (rd_v !== 32'h1) begin miscompares++; $display("FAIL chg_set got %h exp %h", rd_v, 32'h1); end
    rd(B + 32'h0C, rd_v);
    vectors++; if (rd_v !== 32'hA5) begin miscompares++; $display("FAIL capture got %h exp %h", rd_v, 32'hA5); end
    wr(B + 32'h08, 32'h1);
    rd(B + 32'h08, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL chg_w1c got %h exp %h", rd_v, 32'h0); end
  endtask

  task automatic test_timer;
    wr(B + 32'h18, 32'd3);
    wr(B + 32'h14, 32'd0);
    wr(B + 32'h10, 32'h5);
    rd(B + 32'h10, rd_v);
    vectors++; if (rd_v !== 32'h5) begin miscompares++; $display("FAIL ctrl got %h exp %h", rd_v, 32'h5); end
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      rd(B + 32'h14, rd_v);
      vectors++; if (rd_v !== 32'(i % 4)) begin miscompares++; $display("FAIL timer_seq%0d got %h exp %h", i, rd_v, 32'(i % 4)); end
      if (i == 3) begin
        vectors++; if (Irq !== 1'b0) begin miscompares++; $display("FAIL irq_early got %b exp 0", Irq); end
      end
    end
    rd(B + 32'h08, rd_v);
    vectors++; if (rd_v !== 32'h2) begin miscompares++; $display("FAIL tmr_set got %h exp %h", rd_v, 32'h2); end
    vectors++; if (Irq !== 1'b1) begin miscompares++; $display("FAIL irq_tmr got %b exp 1", Irq); end
    wr(B + 32'h08, 32'h2);
    rd(B + 32'h08, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL tmr_w1c got %h exp %h", rd_v, 32'h0); end
    tick(2);
    wr(B + 32'h08, 32'h2);
    rd(B + 32'h08, rd_v);
    vectors++; if (rd_v !== 32'h2) begin miscompares++; $display("FAIL set_beats_clear got %h exp %h", rd_v, 32'h2); end
    rd(B + 32'h14, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL timer_wrap got %h exp %h", rd_v, 32'h0); end
    wr(B + 32'h08, 32'h2);
    tick(2);
    wr(B + 32'h14, 32'h10);
    rd(B + 32'h14, rd_v);
    vectors++; if (rd_v !== 32'h10) begin miscompares++; $display("FAIL timer_write_wins got %h exp %h", rd_v, 32'h10); end
    rd(B + 32'h08, rd_v);
    vectors++; if (rd_v !== 32'h2) begin miscompares++; $display("FAIL tmr_on_write got %h exp %h", rd_v, 32'h2); end
    wr(B + 32'h10, 32'h0);
    tick(1);
    rd(B + 32'h14, rd_v);
    vectors++; if (rd_v !== 32'h11) begin miscompares++; $display("FAIL timer_hold got %h exp %h", rd_v, 32'h11); end
    vectors++; if (Irq !== 1'b0) begin miscompares++; $display("FAIL irq_masked got %b exp 0", Irq); end
    wr(B + 32'h08, 32'h3);
    wr(B + 32'h18, 32'd5);
    wr(B + 32'h14, 32'hFFFF_FFFF);
    wr(B + 32'h10, 32'h1);
    tick(1);
    rd(B + 32'h14, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL count_wrap got %h exp %h", rd_v, 32'h0); end
    rd(B + 32'h08, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL wrap_no_tmr got %h exp %h", rd_v, 32'h0); end
  endtask

  task automatic test_reset_mid;
    PortIn = 8'h3C;
    tick(LAT + 1);
    wr(B, 32'h55);
    wr(B + 32'h10, 32'h7);
    wr(B + 32'h14, 32'h7);
    vectors++; if (Irq !== 1'b1) begin miscompares++; $display("FAIL irq_chg got %b exp 1", Irq); end
    reset = 1'b1;
    tick(1);
    vectors++; if (PortOut !== 32'h0) begin miscompares++; $display("FAIL mid_portout got %h exp %h", PortOut, 32'h0); end
    vectors++; if (Irq !== 1'b0) begin miscompares++; $display("FAIL mid_irq got %b exp 0", Irq); end
    rd(B + 32'h14, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL mid_timer got %h exp %h", rd_v, 32'h0); end
    rd(B + 32'h08, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL mid_status got %h exp %h", rd_v, 32'h0); end
    rd(B + 32'h10, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL mid_ctrl got %h exp %h", rd_v, 32'h0); end
    rd(B + 32'h04, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL mid_in got %h exp %h", rd_v, 32'h0); end
    rd(B + 32'h0C, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL mid_capture got %h exp %h", rd_v, 32'h0); end
    reset = 1'b0;
  endtask

  task automatic test_unmapped;
    wr(B + 32'h1C, 32'hFFFF_FFFF);
    vectors++; if (PortOut !== 32'h0) begin miscompares++; $display("FAIL rsvd_write got %h exp %h", PortOut, 32'h0); end
    rd(B + 32'h1C, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL rsvd_read got %h exp %h", rd_v, 32'h0); end
    rd(B + 32'h10, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL rsvd_ctrl got %h exp %h", rd_v, 32'h0); end
    wr(B + 32'h04, 32'hFF);
    Address = B + 32'h04; MemRead = 1'b0;
    #1;
    vectors++; if (ReadData !== 32'h0) begin miscompares++; $display("FAIL no_read_strobe got %h exp %h", ReadData, 32'h0); end
    rd(32'h1001_0200, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL miss_read got %h exp %h", rd_v, 32'h0); end
    vectors++; if (Select !== 1'b0) begin miscompares++; $display("FAIL miss_select got %b exp 0", Select); end
  endtask

`ifdef IO_DEBOUNCE_EN
  task automatic test_debounce;
    tick(12);
    wr(B + 32'h08, 32'h3);
    PortIn = 8'h81;
    tick(2);
    PortIn = 8'h3C;
    tick(10);
    rd(B + 32'h04, rd_v);
    vectors++; if (rd_v !== 32'h3C) begin miscompares++; $display("FAIL pulse_in got %h exp %h", rd_v, 32'h3C); end
    rd(B + 32'h08, rd_v);
    vectors++; if (rd_v !== 32'h0) begin miscompares++; $display("FAIL pulse_chg got %h exp %h", rd_v, 32'h0); end
    PortIn = 8'h42;
    tick(5);
    rd(B + 32'h04, rd_v);
    vectors++; if (rd_v !== 32'h3C) begin miscompares++; $display("FAIL level_early got %h exp %h", rd_v, 32'h3C); end
    tick(1);
    rd(B + 32'h04, rd_v);
    vectors++; if (rd_v !== 32'h42) begin miscompares++; $display("FAIL level_in got %h exp %h", rd_v, 32'h42); end
    tick(4);
  endtask
`endif

  initial begin
    reset = 1'b1; Address = 32'h0; WriteData = 32'h0;
    MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
    test_reset;
    test_out_port;
    test_input;
    test_timer;
    test_reset_mid;
    test_unmapped;
`ifdef IO_DEBOUNCE_EN
    test_debounce;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
